phy_rx_deserializer: RTL and testbench



---
 rtl/phy_rx_deserializer_pkg.sv | 15 +
 rtl/phy_rx_deserializer_if.sv | 26 ++
 rtl/phy_rx_byte_sync.sv | 103 ++++++++++
 rtl/phy_rx_deserializer.sv | 82 ++++++++
 tb/tb_phy_rx_deserializer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/phy_rx_deserializer_pkg.sv
// Shared constants and FSM encoding for the PHY receive path.
// The serial lane carries bytes MSB first; idle bytes are the COM symbol.
package phy_defs;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam logic [BYTE_W-1:0] COM_SYMBOL = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sync_state_t;

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Serial-in / parallel-out bundle of the receive deserializer.
// The state member exposes the byte-alignment FSM so checkers can observe it.
interface phy_rx_deserializer_if;
    import phy_defs::*;

    // serial_in is sampled on every clk_32f rising edge with no back-pressure.
    // valid_out is a one-cycle qualifier for data_out and has no ready;
    // the consumer must take the word in the cycle the strobe is high.
    logic                serial_in;
    logic [WORD_W-1:0]   data_out;
    logic                valid_out;
    logic                active;
    logic                frag_err;
    sync_state_t         state;

    modport master (
        output serial_in,
        input  data_out, valid_out, active, frag_err, state
    );

    modport slave (
        input  serial_in,
        output data_out, valid_out, active, frag_err, state
    );

endinterface

// File: rtl/phy_rx_byte_sync.sv
// Byte alignment: slides a window over the serial lane until COM is found,
// then confirms SYNC_COUNT aligned COMs before presenting bytes downstream.
module phy_rx_byte_sync
    import phy_defs::*;
#(
    parameter logic [7:0] COM_SYMBOL = phy_defs::COM_SYMBOL,
    parameter int         SYNC_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        serial_in,
    output logic [7:0]  rx_byte,
    output logic        byte_strobe,
    output logic        is_com,
    output logic        active,
    output sync_state_t state
);

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic        active_q, active_d;
    sync_state_t state_q, state_d;

    logic [7:0]  window;
    logic        match;
    logic        boundary;

    // The window includes the bit being sampled on this edge.
    assign window   = {shift_q[6:0], serial_in};
    assign match    = (window == COM_SYMBOL);
    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            active_q  <= 1'b0;
            state_q   <= SEARCH;
        end else begin
            shift_q   <= window;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            active_q  <= active_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        case (state_q)
            SEARCH: begin
                bit_cnt_d = 3'd0;
                if (match) begin
                    com_cnt_d = 4'd1;
                    if (SYNC_TARGET == 4'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (match) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == SYNC_TARGET) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Misaligned: restart the sliding search on the next bit.
                        com_cnt_d = 4'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
            end
            default: begin
                state_d   = SEARCH;
                bit_cnt_d = 3'd0;
                com_cnt_d = 4'd0;
                active_d  = 1'b0;
            end
        endcase
    end

    assign rx_byte     = window;
    assign byte_strobe = (state_q == ACTIVE) && boundary;
    assign is_com      = match;
    assign active      = active_q;
    assign state       = state_q;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer top: byte alignment plus a word assembler that packs
// four data bytes (first byte in [31:24]) and drops idle COMs.
module phy_rx_deserializer
    import phy_defs::*;
#(
    parameter logic [7:0] COM_SYMBOL = phy_defs::COM_SYMBOL,
    parameter int         SYNC_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    phy_rx_deserializer_if.slave  bus
);

    logic [7:0]        rx_byte;
    logic              byte_strobe;
    logic              is_com;
    logic              sync_active;
    sync_state_t       sync_state;

    logic [1:0]        byte_idx_q;
    logic [WORD_W-1:0] data_reg_q;
    logic [WORD_W-1:0] data_out_q;
    logic              valid_q;
    logic              frag_q;

    phy_rx_byte_sync #(
        .COM_SYMBOL (COM_SYMBOL),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_byte_sync (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .serial_in   (bus.serial_in),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .is_com      (is_com),
        .active      (sync_active),
        .state       (sync_state)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            byte_idx_q <= 2'd0;
            data_reg_q <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            frag_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            frag_q  <= 1'b0;
            if (byte_strobe) begin
                if (is_com) begin
                    // An idle byte inside a word means the partial word is lost.
                    if (byte_idx_q != 2'd0) begin
                        byte_idx_q <= 2'd0;
                        frag_q     <= 1'b1;
                    end
                end else begin
                    case (byte_idx_q)
                        2'd0:    data_reg_q[31:24] <= rx_byte;
                        2'd1:    data_reg_q[23:16] <= rx_byte;
                        2'd2:    data_reg_q[15:8]  <= rx_byte;
                        default: data_reg_q[7:0]   <= rx_byte;
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        data_out_q <= {data_reg_q[31:8], rx_byte};
                        valid_q    <= 1'b1;
                        byte_idx_q <= 2'd0;
                    end else begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.frag_err  = frag_q;
    assign bus.active    = sync_active;
    assign bus.state     = sync_state;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for the receive deserializer: alignment, word assembly,
// fragment discard, alignment loss, mid-word reset and back-to-back words.
module tb_phy_rx_deserializer;
    import phy_defs::*;

    localparam logic [7:0] COM = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    phy_rx_deserializer_if bus ();

    phy_rx_deserializer #(
        .COM_SYMBOL (8'hBC),
        .SYNC_COUNT (4)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    // clock / reset
    always #5 clk_32f = ~clk_32f;

    int checks   = 0;
    int failures = 0;

    // output monitor, sampled mid-cycle
    int          cyc       = 0;
    int          valid_cnt = 0;
    int          frag_cnt  = 0;
    int          both_cnt  = 0;
    logic [31:0] got_q[$];
    int          strobe_cyc_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk_32f) begin
        cyc = cyc + 1;
        if (bus.valid_out === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(bus.data_out);
            strobe_cyc_q.push_back(cyc);
        end
        if (bus.frag_err === 1'b1) frag_cnt = frag_cnt + 1;
        if (bus.valid_out === 1'b1 && bus.frag_err === 1'b1) both_cnt = both_cnt + 1;
    end

    // driver tasks
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        bus.serial_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_head(input logic [7:0] b);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk_32f);
        reset = 1'b1;
        bus.serial_in = 1'b0;
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic sync_lane();
        for (int i = 0; i < 4; i++) send_byte(COM);
    endtask

    task automatic test_reset();
        @(negedge clk_32f);
        reset = 1'b1;
        bus.serial_in = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        checks++; if (bus.data_out !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected %h", bus.data_out, 32'h0); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b expected 0", bus.active); end
        checks++; if (bus.frag_err !== 1'b0) begin failures++; $display("FAIL reset_frag: got %b expected 0", bus.frag_err); end
        checks++; if (bus.state !== SEARCH) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state, SEARCH); end
        reset = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic test_align();
        int v0;
        apply_reset();
        v0 = valid_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(COM);
        checks++; if (bus.state !== ALIGN) begin failures++; $display("FAIL align_state3: got %0d expected %0d", bus.state, ALIGN); end
        send_head(COM);
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL align_early: got %b expected 0", bus.active); end
        send_bit(1'b0);
        checks++; if (bus.active !== 1'b1) begin failures++; $display("FAIL align_active: got %b expected 1", bus.active); end
        checks++; if (bus.state !== ACTIVE) begin failures++; $display("FAIL align_state4: got %0d expected %0d", bus.state, ACTIVE); end
        send_bit(1'b0);
        checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL align_novalid: got %0d expected %0d", valid_cnt - v0, 0); end
    endtask

    task automatic test_word();
        int v0;
        int f0;
        apply_reset();
        sync_lane();
        v0 = valid_cnt;
        f0 = frag_cnt;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        send_head(8'h78);
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL word_early: got %b expected 0", bus.valid_out); end
        send_bit(1'b0);
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL word_valid: got %b expected 1", bus.valid_out); end
        checks++; if (bus.data_out !== 32'h12345678) begin failures++; $display("FAIL word_data: got %h expected %h", bus.data_out, 32'h12345678); end
        send_bit(1'b0);
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL word_pulse: got %b expected 0", bus.valid_out); end
        checks++; if (bus.data_out !== 32'h12345678) begin failures++; $display("FAIL word_hold: got %h expected %h", bus.data_out, 32'h12345678); end
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL word_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (frag_cnt - f0 !== 0) begin failures++; $display("FAIL word_nofrag: got %0d expected 0", frag_cnt - f0); end
    endtask

    task automatic test_frag();
        int f0;
        apply_reset();
        sync_lane();
        f0 = frag_cnt;
        send_byte(8'hAA); send_byte(8'hBB);
        send_head(COM);
        checks++; if (bus.frag_err !== 1'b0) begin failures++; $display("FAIL frag_early: got %b expected 0", bus.frag_err); end
        send_bit(1'b0);
        checks++; if (bus.frag_err !== 1'b1) begin failures++; $display("FAIL frag_pulse: got %b expected 1", bus.frag_err); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL frag_novalid: got %b expected 0", bus.valid_out); end
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL frag_word_valid: got %b expected 1", bus.valid_out); end
        checks++; if (bus.data_out !== 32'h01020304) begin failures++; $display("FAIL frag_word_data: got %h expected %h", bus.data_out, 32'h01020304); end
        send_bit(1'b0);
        checks++; if (frag_cnt - f0 !== 1) begin failures++; $display("FAIL frag_count: got %0d expected 1", frag_cnt - f0); end
    endtask

    task automatic test_align_loss();
        apply_reset();
        send_byte(COM); send_byte(COM);
        checks++; if (bus.state !== ALIGN) begin failures++; $display("FAIL loss_align: got %0d expected %0d", bus.state, ALIGN); end
        send_byte(8'h00);
        checks++; if (bus.state !== SEARCH) begin failures++; $display("FAIL loss_search: got %0d expected %0d", bus.state, SEARCH); end
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL loss_active: got %b expected 0", bus.active); end
        send_byte(COM); send_byte(COM); send_byte(COM);
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL loss_resync3: got %b expected 0", bus.active); end
        send_byte(COM);
        checks++; if (bus.active !== 1'b1) begin failures++; $display("FAIL loss_resync4: got %b expected 1", bus.active); end
    endtask

    task automatic test_reset_mid();
        int f0;
        apply_reset();
        sync_lane();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++; if (bus.data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_pre_word: got %h expected %h", bus.data_out, 32'hDEADBEEF); end
        send_byte(8'h11); send_byte(8'h22);
        f0 = frag_cnt;
        @(negedge clk_32f);
        reset = 1'b1;
        bus.serial_in = 1'b0;
        @(posedge clk_32f);
        #1;
        checks++; if (bus.data_out !== 32'h0) begin failures++; $display("FAIL mid_data: got %h expected %h", bus.data_out, 32'h0); end
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL mid_active: got %b expected 0", bus.active); end
        checks++; if (bus.state !== SEARCH) begin failures++; $display("FAIL mid_state: got %0d expected %0d", bus.state, SEARCH); end
        reset = 1'b0;
        sync_lane();
        checks++; if (bus.active !== 1'b1) begin failures++; $display("FAIL mid_resync: got %b expected 1", bus.active); end
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL mid_valid: got %b expected 1", bus.valid_out); end
        checks++; if (bus.data_out !== 32'hA1B2C3D4) begin failures++; $display("FAIL mid_word: got %h expected %h", bus.data_out, 32'hA1B2C3D4); end
        send_bit(1'b0);
        checks++; if (frag_cnt - f0 !== 0) begin failures++; $display("FAIL mid_nofrag: got %0d expected 0", frag_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        logic [31:0] got_w;
        apply_reset();
        sync_lane();
        got_q.delete();
        strobe_cyc_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h00010203);
        exp_q.push_back(32'h04050607);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        send_bit(1'b0);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
        if (strobe_cyc_q.size() == 2) begin
            checks++; if (strobe_cyc_q[1] - strobe_cyc_q[0] !== 32) begin failures++; $display("FAIL b2b_spacing: got %0d expected 32", strobe_cyc_q[1] - strobe_cyc_q[0]); end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = got_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL b2b_word: got %h expected %h", got_w, exp_w); end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_frag_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        bus.serial_in = 1'b0;
        test_reset();
        test_align();
        test_word();
        test_frag();
        test_align_loss();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
